// File: rtl/sdrc_wb_bist_master.sv
// Wishbone BIST master for the SDRAM controller application port: writes NUM bursts
// of a generated pattern from a base address, reads them back and reports the result.
module sdrc_wb_bist_master #(
   parameter int AW  = 26,
   parameter int DW  = 32,
   parameter int BL  = 8,
   parameter int TMO = 1023
) (
   input  logic            wb_clk_i,
   input  logic            wb_rst_i,
   input  logic            start,
   input  logic [AW-1:0]   base_addr,
   input  logic [15:0]     num_bursts,
   input  logic [1:0]      pat_sel,
   input  logic            sdr_init_done,
   output logic            wb_cyc_o,
   output logic            wb_stb_o,
   output logic            wb_we_o,
   output logic [AW-1:0]   wb_addr_o,
   output logic [DW-1:0]   wb_dat_o,
   output logic [DW/8-1:0] wb_sel_o,
   output logic [2:0]      wb_cti_o,
   input  logic            wb_ack_i,
   input  logic [DW-1:0]   wb_dat_i,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic            timeout,
   output logic [15:0]     err_cnt,
   output logic [AW-1:0]   first_err_addr
);

   localparam int BW = $clog2(BL + 1);
   localparam int TW = $clog2(TMO + 1);
   localparam logic [AW-1:0] STEP  = AW'(DW / 8);
   localparam logic [AW-1:0] ALIGN = ~AW'(DW / 8 - 1);
   localparam logic [31:0]   SEED  = 32'hACE1_0001;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_WAIT   = 3'd1;
   localparam logic [2:0] S_WR     = 3'd2;
   localparam logic [2:0] S_WR_GAP = 3'd3;
   localparam logic [2:0] S_RD     = 3'd4;
   localparam logic [2:0] S_RD_GAP = 3'd5;
   localparam logic [2:0] S_FIN    = 3'd6;

   logic [2:0]    state_q, state_d;
   logic [AW-1:0] addr_q, addr_d, base_q, base_d, ferr_q, ferr_d;
   logic [15:0]   num_q, num_d, burst_q, burst_d, err_q, err_d;
   logic [1:0]    pat_q, pat_d;
   logic [BW-1:0] beat_q, beat_d;
   logic [31:0]   lfsr_q, lfsr_d;
   logic [DW-1:0] walk_q, walk_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          busy_q, busy_d, done_q, done_d, pass_q, pass_d, tout_q, tout_d;
   logic [DW-1:0] pat_data;
   logic          active, last_beat, fin, reseed;

   assign active    = (state_q == S_WR) || (state_q == S_RD);
   assign last_beat = (beat_q == BW'(BL - 1));

   always_comb begin
      pat_data = DW'(addr_q);
      case (pat_q)
         2'd1:    pat_data = DW'(lfsr_q);
         2'd2:    pat_data = walk_q;
         2'd3:    pat_data = ~DW'(addr_q);
         default: pat_data = DW'(addr_q);
      endcase
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      base_d  = base_q;
      ferr_d  = ferr_q;
      num_d   = num_q;
      burst_d = burst_q;
      err_d   = err_q;
      pat_d   = pat_q;
      beat_d  = beat_q;
      lfsr_d  = lfsr_q;
      walk_d  = walk_q;
      tmo_d   = tmo_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      pass_d  = pass_q;
      tout_d  = tout_q;
      fin     = 1'b0;
      reseed  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               base_d  = base_addr & ALIGN;
               addr_d  = base_addr & ALIGN;
               num_d   = num_bursts;
               pat_d   = pat_sel;
               err_d   = '0;
               ferr_d  = '0;
               pass_d  = 1'b0;
               tout_d  = 1'b0;
               busy_d  = 1'b1;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (sdr_init_done) begin
               if (num_q == 16'd0) begin
                  fin = 1'b1;
               end else begin
                  reseed  = 1'b1;
                  state_d = S_WR;
               end
            end
         end
         S_WR, S_RD: begin
            if (wb_ack_i) begin
               tmo_d  = '0;
               addr_d = addr_q + STEP;
               lfsr_d = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
               walk_d = {walk_q[DW-2:0], walk_q[DW-1]};
               if ((state_q == S_RD) && (wb_dat_i != pat_data)) begin
                  if (err_q == 16'd0) ferr_d = addr_q;
                  if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
               end
               if (last_beat) begin
                  beat_d  = '0;
                  burst_d = burst_q + 16'd1;
                  if (state_q == S_WR) state_d = S_WR_GAP;
                  else if (burst_q == num_q - 16'd1) fin = 1'b1;
                  else state_d = S_RD_GAP;
               end else begin
                  beat_d = beat_q + BW'(1);
               end
            end else if (tmo_q == TW'(TMO - 1)) begin
               tout_d = 1'b1;
               fin    = 1'b1;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         S_WR_GAP: begin
            if (burst_q == num_q) begin
               reseed  = 1'b1;
               state_d = S_RD;
            end else begin
               state_d = S_WR;
            end
         end
         S_RD_GAP: state_d = S_RD;
         S_FIN:    state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase

      // Both phases start from the same address and generator state so reads
      // regenerate exactly the written sequence.
      if (reseed) begin
         addr_d  = base_q;
         lfsr_d  = SEED;
         walk_d  = DW'(1);
         beat_d  = '0;
         burst_d = '0;
         tmo_d   = '0;
      end
      if (fin) begin
         state_d = S_FIN;
         busy_d  = 1'b0;
         done_d  = 1'b1;
         pass_d  = (err_d == 16'd0) && !tout_d;
      end
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         base_q  <= '0;
         ferr_q  <= '0;
         num_q   <= '0;
         burst_q <= '0;
         err_q   <= '0;
         pat_q   <= '0;
         beat_q  <= '0;
         lfsr_q  <= '0;
         walk_q  <= '0;
         tmo_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         tout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         base_q  <= base_d;
         ferr_q  <= ferr_d;
         num_q   <= num_d;
         burst_q <= burst_d;
         err_q   <= err_d;
         pat_q   <= pat_d;
         beat_q  <= beat_d;
         lfsr_q  <= lfsr_d;
         walk_q  <= walk_d;
         tmo_q   <= tmo_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         tout_q  <= tout_d;
      end
   end

   assign wb_cyc_o       = active;
   assign wb_stb_o       = active;
   assign wb_we_o        = (state_q == S_WR);
   assign wb_addr_o      = addr_q;
   assign wb_dat_o       = pat_data;
   assign wb_sel_o       = '1;
   assign wb_cti_o       = !active ? 3'b000 : (last_beat ? 3'b111 : 3'b010);
   assign busy           = busy_q;
   assign done           = done_q;
   assign pass           = pass_q;
   assign timeout        = tout_q;
   assign err_cnt        = err_q;
   assign first_err_addr = ferr_q;

endmodule
